// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU)
// One shift-add or restoring shift-subtract step per clock on operand magnitudes.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MTHI,
  input  logic             MTLO,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    sign_a    = ~Op[0] & A[WIDTH-1];
    sign_b    = ~Op[0] & B[WIDTH-1];
    mag_a     = sign_a ? -A : A;
    mag_b     = sign_b ? -B : B;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    // When the subtract succeeds the difference is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opb;
    prod_neg  = -{acc_hi, acc_lo};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opb      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      Hi       <= '0;
      Lo       <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            is_div   <= Op[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= Op[1] && (B == '0);
            opb      <= mag_b;
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= S_RUN;
          end else begin
            if (MTHI) Hi <= A;
            if (MTLO) Lo <= A;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            // With a zero divisor the remainder ends up as |A|; the dividend-sign fix restores A.
            Lo <= div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
            Hi <= neg_rem ? -acc_hi : acc_hi;
          end else begin
            {Hi, Lo} <= neg_res ? prod_neg : {acc_hi, acc_lo};
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, MTHI, MTLO, Busy, Done;
  logic [1:0]   Op;
  logic [W-1:0] A, B, Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .MTHI(MTHI), .MTLO(MTLO), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          lo = 32'(q);
          hi = 32'(r);
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string tag);
    logic [31:0] eh, el;
    int n;
    bit seen;
    model(op, a, b, eh, el);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
    A = $urandom; B = $urandom;
    check({tag, "_busy_start"}, Busy, 1);
    check({tag, "_done_start"}, Done, 0);
    n = 1;
    seen = 0;
    while (!seen && n < 100) begin
      if (disturb && n == 10) begin
        Start = 1'b1; Op = ~op; MTHI = 1'b1; A = 32'h1234; B = 32'h5;
      end
      @(posedge Clk); n++; #1;
      Start = 1'b0; MTHI = 1'b0;
      if (n == 20) begin
        check({tag, "_hold_hi"}, Hi, m_hi);
        check({tag, "_hold_lo"}, Lo, m_lo);
      end
      seen = Done;
    end
    check({tag, "_latency"}, n, 34);
    check({tag, "_hi"}, Hi, eh);
    check({tag, "_lo"}, Lo, el);
    check({tag, "_busy_end"}, Busy, 0);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic idle();
    @(posedge Clk); #1;
  endtask

  initial begin
    int dcount;
    logic [31:0] r;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    Reset = 1'b1; Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0; Op = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0, "mult"); idle();
    check("mult_exact_hi", m_hi, 32'hFFFF_FFFF);
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 0, "multu"); idle();
    check("multu_exact_hi", Hi, 32'h0000_0002);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div"); idle();
    check("div_exact_lo", Lo, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, 0, "divu"); idle();
    check("divu_exact_lo", Lo, 32'h0000_000E);
    run_op(2'b11, 32'd5, 32'd0, 0, "divu_zero"); idle();
    check("divu_zero_hi", Hi, 32'd5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, "div_zero"); idle();
    check("div_zero_hi", Hi, 32'hFFFF_FFF9);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf"); idle();
    check("div_ovf_lo", Lo, 32'h8000_0000);

    // Abort a MULTU with reset partway through.
    Start = 1'b1; Op = 2'b01; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort_busy", Busy, 0);
    check("abort_hi", Hi, 0);
    check("abort_lo", Lo, 0);
    check("abort_done", Done, 0);
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    run_op(2'b01, 32'd5, 32'd6, 0, "after_abort"); idle();

    run_op(2'b01, 32'h0001_2345, 32'h0000_0777, 1, "busy_ignore"); idle();

    MTLO = 1'b1; A = 32'hABCD;
    @(posedge Clk); #1;
    MTLO = 1'b0;
    check("mtlo_lo", Lo, 32'hABCD);
    check("mtlo_hi", Hi, m_hi);
    m_lo = 32'hABCD;

    r = $urandom;
    MTHI = 1'b1; MTLO = 1'b1; A = r;
    @(posedge Clk); #1;
    MTHI = 1'b0; MTLO = 1'b0;
    check("mtboth_hi", Hi, r);
    check("mtboth_lo", Lo, r);
    m_hi = r; m_lo = r;

    MTHI = 1'b1; MTLO = 1'b1;
    run_op(2'b00, 32'hFFFF_FF00, 32'h0000_0100, 0, "start_wins"); idle();

    run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 0, "b2b_a");
    run_op(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, "b2b_b");
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 0, "b2b_c"); idle();
    check("b2b_done_clear", Done, 0);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 0) rb = '0;
      if (i % 4 == 1) rb = $urandom_range(1, 9);
      if (i % 4 == 2) ra = $urandom_range(0, 20);
      run_op(rop, ra, rb, 0, $sformatf("rand%0d", i));
      if (i % 3 != 0) idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
